// File: rtl/trace_pkg.sv
// Shared definitions for the trigger clock controller: FSM state encoding,
// DRP bus widths and error-bit positions.
package trace_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PS_PULSE  = 3'd1,
        ST_PS_WAIT   = 3'd2,
        ST_DRP_ISSUE = 3'd3,
        ST_DRP_WAIT  = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

    localparam int DRP_ADDR_W = 7;
    localparam int DRP_DATA_W = 16;

    localparam int ERR_TIMEOUT = 0;
    localparam int ERR_UNLOCK  = 1;

endpackage

// File: rtl/cdc_simple.sv
// Two-flop synchronizer for a single slow, level-type asynchronous signal.
module cdc_simple (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/trig_clk_ctrl.sv
// Trigger clock controller: sequences MMCM dynamic phase shifts and DRP
// register accesses from single-cycle go pulses.
// Optional build macro TRIG_CLK_CTRL_TIMEOUT_EN adds a pTIMEOUT-cycle limit
// on the psdone/drdy waits; without it the waits are unbounded and
// O_error[0] stays 0.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | waiting for a go pulse or a pending phase-shift request
// ST_PS_PULSE  | check lock, drive psen for one cycle
// ST_PS_WAIT   | waiting for psdone, then count the step
// ST_DRP_ISSUE | drive den (and dwe on writes) for one cycle
// ST_DRP_WAIT  | waiting for drdy, capture read data
// ST_DONE      | one-cycle completion pulse
module trig_clk_ctrl
    import trace_pkg::*;
#(
    parameter int pSTEP_W  = 16,
    parameter int pTIMEOUT = 255
) (
    input  logic                  usb_clk,
    input  logic                  reset_i,
    input  logic                  I_ps_go,
    input  logic [pSTEP_W-1:0]    I_ps_steps,
    input  logic                  I_drp_go,
    input  logic                  I_drp_write,
    input  logic [DRP_ADDR_W-1:0] I_drp_addr,
    input  logic [DRP_DATA_W-1:0] I_drp_wdata,
    input  logic                  I_clear_error,
    input  logic                  I_locked,
    input  logic                  I_psdone,
    input  logic                  I_drdy,
    input  logic [DRP_DATA_W-1:0] I_dout,
    output logic                  O_psen,
    output logic                  O_psincdec,
    output logic [DRP_ADDR_W-1:0] O_daddr,
    output logic                  O_den,
    output logic                  O_dwe,
    output logic [DRP_DATA_W-1:0] O_din,
    output logic [DRP_DATA_W-1:0] O_drp_rdata,
    output logic [pSTEP_W-1:0]    O_phase,
    output logic                  O_busy,
    output logic                  O_done,
    output logic [1:0]            O_error
);

    state_e                  state_q, state_d;
    logic                    pend_q, pend_d;
    logic [pSTEP_W-1:0]      pend_steps_q, pend_steps_d;
    logic                    incdec_q, incdec_d;
    logic [pSTEP_W-1:0]      rem_q, rem_d;
    logic [pSTEP_W-1:0]      phase_q, phase_d;
    logic                    write_q, write_d;
    logic [DRP_ADDR_W-1:0]   addr_q, addr_d;
    logic [DRP_DATA_W-1:0]   wdata_q, wdata_d;
    logic [DRP_DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]              err_q, err_d;
    logic [1:0]              err_set;
    logic                    psen;
    logic                    den;
    logic                    done;
    logic                    start_ps;
    logic [pSTEP_W-1:0]      start_steps;
    logic                    locked_s;

`ifdef TRIG_CLK_CTRL_TIMEOUT_EN
    localparam int TMR_W = (pTIMEOUT > 1) ? $clog2(pTIMEOUT) : 1;
    logic [TMR_W-1:0]        tmr_q, tmr_d;
`endif

    cdc_simple u_locked_sync (
        .clk_i (usb_clk),
        .rst_i (reset_i),
        .d_i   (I_locked),
        .q_o   (locked_s)
    );

    // State register and all datapath registers.
    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            pend_q       <= 1'b0;
            pend_steps_q <= '0;
            incdec_q     <= 1'b0;
            rem_q        <= '0;
            phase_q      <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 2'b00;
`ifdef TRIG_CLK_CTRL_TIMEOUT_EN
            tmr_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            pend_steps_q <= pend_steps_d;
            incdec_q     <= incdec_d;
            rem_q        <= rem_d;
            phase_q      <= phase_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
`ifdef TRIG_CLK_CTRL_TIMEOUT_EN
            tmr_q        <= tmr_d;
`endif
        end
    end

    // Next-state, datapath updates and single-cycle strobes.
    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        pend_steps_d = pend_steps_q;
        incdec_d     = incdec_q;
        rem_d        = rem_q;
        phase_d      = phase_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_set      = 2'b00;
        psen         = 1'b0;
        den          = 1'b0;
        done         = 1'b0;
        start_ps     = 1'b0;
        start_steps  = I_ps_steps;
`ifdef TRIG_CLK_CTRL_TIMEOUT_EN
        tmr_d        = tmr_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    // A phase shift deferred behind a DRP access runs first.
                    pend_d      = 1'b0;
                    start_ps    = 1'b1;
                    start_steps = pend_steps_q;
                end else if (I_drp_go) begin
                    write_d = I_drp_write;
                    addr_d  = I_drp_addr;
                    wdata_d = I_drp_wdata;
                    state_d = ST_DRP_ISSUE;
                    if (I_ps_go) begin
                        pend_d       = 1'b1;
                        pend_steps_d = I_ps_steps;
                    end
                end else if (I_ps_go) begin
                    start_ps = 1'b1;
                end
            end

            ST_PS_PULSE: begin
                if (!locked_s) begin
                    err_set[ERR_UNLOCK] = 1'b1;
                    state_d             = ST_DONE;
                end else begin
                    psen    = 1'b1;
                    state_d = ST_PS_WAIT;
`ifdef TRIG_CLK_CTRL_TIMEOUT_EN
                    tmr_d   = TMR_W'(pTIMEOUT - 1);
`endif
                end
            end

            ST_PS_WAIT: begin
                if (I_psdone) begin
                    phase_d = incdec_q ? (phase_q + pSTEP_W'(1))
                                       : (phase_q - pSTEP_W'(1));
                    rem_d   = rem_q - pSTEP_W'(1);
                    state_d = (rem_q == pSTEP_W'(1)) ? ST_DONE : ST_PS_PULSE;
                end
`ifdef TRIG_CLK_CTRL_TIMEOUT_EN
                else if (tmr_q == '0) begin
                    // Remaining steps are dropped; O_phase keeps what was applied.
                    err_set[ERR_TIMEOUT] = 1'b1;
                    rem_d                = '0;
                    state_d              = ST_DONE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
`endif
            end

            ST_DRP_ISSUE: begin
                den     = 1'b1;
                state_d = ST_DRP_WAIT;
`ifdef TRIG_CLK_CTRL_TIMEOUT_EN
                tmr_d   = TMR_W'(pTIMEOUT - 1);
`endif
            end

            ST_DRP_WAIT: begin
                if (I_drdy) begin
                    if (!write_q) begin
                        rdata_d = I_dout;
                    end
                    state_d = ST_DONE;
                end
`ifdef TRIG_CLK_CTRL_TIMEOUT_EN
                else if (tmr_q == '0) begin
                    err_set[ERR_TIMEOUT] = 1'b1;
                    state_d              = ST_DONE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
`endif
            end

            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_ps) begin
            // Magnitude of the most-negative step count is representable
            // as an unsigned value of the same width.
            incdec_d = !start_steps[pSTEP_W-1] && (start_steps != '0);
            rem_d    = start_steps[pSTEP_W-1] ? (~start_steps + pSTEP_W'(1))
                                              : start_steps;
            state_d  = (start_steps == '0) ? ST_DONE : ST_PS_PULSE;
        end

        // A new error in the same cycle as a clear still gets recorded.
        err_d = (I_clear_error ? 2'b00 : err_q) | err_set;
    end

    assign O_psen      = psen;
    assign O_psincdec  = incdec_q;
    assign O_daddr     = addr_q;
    assign O_den       = den;
    assign O_dwe       = den & write_q;
    assign O_din       = wdata_q;
    assign O_drp_rdata = rdata_q;
    assign O_phase     = phase_q;
    assign O_busy      = (state_q != ST_IDLE);
    assign O_done      = done;
    assign O_error     = err_q;

endmodule

// File: tb/tb_trig_clk_ctrl.sv
// Scoreboard bench for trig_clk_ctrl: each request pushes its expected
// completion record; a monitor pops and compares on every O_done.
module tb_trig_clk_ctrl;

    logic        usb_clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        I_ps_go = 1'b0;
    logic [15:0] I_ps_steps = '0;
    logic        I_drp_go = 1'b0;
    logic        I_drp_write = 1'b0;
    logic [6:0]  I_drp_addr = '0;
    logic [15:0] I_drp_wdata = '0;
    logic        I_clear_error = 1'b0;
    logic        I_locked = 1'b1;
    logic        I_psdone = 1'b0;
    logic        I_drdy = 1'b0;
    logic [15:0] I_dout = '0;
    logic        O_psen, O_psincdec, O_den, O_dwe, O_busy, O_done;
    logic [6:0]  O_daddr;
    logic [15:0] O_din, O_drp_rdata, O_phase;
    logic [1:0]  O_error;

    trig_clk_ctrl #(.pSTEP_W(16), .pTIMEOUT(255)) dut (
        .usb_clk(usb_clk), .reset_i(reset_i),
        .I_ps_go(I_ps_go), .I_ps_steps(I_ps_steps),
        .I_drp_go(I_drp_go), .I_drp_write(I_drp_write),
        .I_drp_addr(I_drp_addr), .I_drp_wdata(I_drp_wdata),
        .I_clear_error(I_clear_error), .I_locked(I_locked),
        .I_psdone(I_psdone), .I_drdy(I_drdy), .I_dout(I_dout),
        .O_psen(O_psen), .O_psincdec(O_psincdec), .O_daddr(O_daddr),
        .O_den(O_den), .O_dwe(O_dwe), .O_din(O_din),
        .O_drp_rdata(O_drp_rdata), .O_phase(O_phase), .O_busy(O_busy),
        .O_done(O_done), .O_error(O_error)
    );

    always #5 usb_clk = ~usb_clk;

    typedef struct {
        logic [15:0] phase;
        int          psen_n;
        int          den_n;
        logic        chk_dir;
        logic        incdec;
        logic [1:0]  err;
        logic [15:0] rdata;
        logic        chk_drp;
        logic [6:0]  daddr;
        logic        dwe;
        logic [15:0] din;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int psen_total = 0;
    int den_total = 0;
    int done_total = 0;
    int psen_last = 0;
    int den_last = 0;
    logic        psdone_en = 1'b1;
    logic [15:0] drp_rd_val = 16'h1234;
    logic [6:0]  cap_daddr = '0;
    logic        cap_dwe = 1'b0;
    logic [15:0] cap_din = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] ph, input int np, input int nd,
                                input logic cd, input logic id, input logic [1:0] er,
                                input logic [15:0] rd);
        exp_t e;
        e.phase = ph; e.psen_n = np; e.den_n = nd; e.chk_dir = cd; e.incdec = id;
        e.err = er; e.rdata = rd; e.chk_drp = 1'b0; e.daddr = '0; e.dwe = 1'b0; e.din = '0;
        return e;
    endfunction

    // Pulse counters, sampled away from the active edge.
    always @(negedge usb_clk) begin
        if (O_psen) psen_total++;
        if (O_den) begin
            den_total++;
            cap_daddr = O_daddr;
            cap_dwe   = O_dwe;
            cap_din   = O_din;
        end
    end

    // Scoreboard monitor.
    always @(negedge usb_clk) begin
        exp_t e;
        if (!reset_i && O_done) begin
            done_total++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("phase", 32'(O_phase), 32'(e.phase));
                chk("psen_count", 32'(psen_total - psen_last), 32'(e.psen_n));
                chk("den_count", 32'(den_total - den_last), 32'(e.den_n));
                chk("error", 32'(O_error), 32'(e.err));
                chk("drp_rdata", 32'(O_drp_rdata), 32'(e.rdata));
                if (e.chk_dir) chk("psincdec", 32'(O_psincdec), 32'(e.incdec));
                if (e.chk_drp) begin
                    chk("daddr", 32'(cap_daddr), 32'(e.daddr));
                    chk("dwe", 32'(cap_dwe), 32'(e.dwe));
                    chk("din", 32'(cap_din), 32'(e.din));
                end
            end
            psen_last = psen_total;
            den_last  = den_total;
        end
    end

    // MMCM phase-shift model: psdone four cycles after each psen.
    initial forever begin
        @(negedge usb_clk);
        if (O_psen && psdone_en) begin
            repeat (4) @(posedge usb_clk);
            #1 I_psdone = 1'b1;
            @(posedge usb_clk);
            #1 I_psdone = 1'b0;
        end
    end

    // DRP model: drdy two cycles after den.
    initial forever begin
        @(negedge usb_clk);
        if (O_den) begin
            repeat (2) @(posedge usb_clk);
            #1 begin I_drdy = 1'b1; I_dout = drp_rd_val; end
            @(posedge usb_clk);
            #1 begin I_drdy = 1'b0; I_dout = '0; end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge usb_clk);
        #1;
    endtask

    task automatic wait_done(input int n, input int budget, input string name);
        int target;
        target = done_total + n;
        for (int i = 0; i < budget && done_total < target; i++) @(posedge usb_clk);
        #1;
        if (done_total < target) chk({"timeout_", name}, 32'(done_total), 32'(target));
        cycles(1);
    endtask

    task automatic ps_go(input logic [15:0] steps);
        @(posedge usb_clk);
        #1 begin I_ps_go = 1'b1; I_ps_steps = steps; end
        @(posedge usb_clk);
        #1 I_ps_go = 1'b0;
    endtask

    task automatic drp_go(input logic wr, input logic [6:0] a, input logic [15:0] d, input logic with_ps);
        @(posedge usb_clk);
        #1 begin
            I_drp_go = 1'b1; I_drp_write = wr; I_drp_addr = a; I_drp_wdata = d;
            if (with_ps) begin I_ps_go = 1'b1; I_ps_steps = 16'd1; end
        end
        @(posedge usb_clk);
        #1 begin I_drp_go = 1'b0; I_ps_go = 1'b0; end
    endtask

    task automatic clear_err();
        @(posedge usb_clk);
        #1 I_clear_error = 1'b1;
        @(posedge usb_clk);
        #1 I_clear_error = 1'b0;
        chk("error_cleared", 32'(O_error), 32'd0);
    endtask

    initial begin
        exp_t e;
        int base;
        cycles(3);
        chk("rst_phase", 32'(O_phase), 32'd0);
        chk("rst_busy", 32'(O_busy), 32'd0);
        chk("rst_error", 32'(O_error), 32'd0);
        chk("rst_psen", 32'(O_psen), 32'd0);
        chk("rst_rdata", 32'(O_drp_rdata), 32'd0);
        reset_i = 1'b0;
        cycles(5);

        // +3 steps; a DRP go issued mid-sequence must be ignored.
        exp_q.push_back(mk(16'd3, 3, 0, 1'b1, 1'b1, 2'b00, 16'h0000));
        ps_go(16'd3);
        chk("busy_after_accept", 32'(O_busy), 32'd1);
        cycles(2);
        I_drp_go = 1'b1;
        cycles(1);
        I_drp_go = 1'b0;
        wait_done(1, 100, "ps_plus3");

        // -2 steps from phase 3.
        exp_q.push_back(mk(16'd1, 2, 0, 1'b1, 1'b0, 2'b00, 16'h0000));
        ps_go(16'hFFFE);
        wait_done(1, 100, "ps_minus2");

        // Zero steps: done the very next cycle, no psen.
        exp_q.push_back(mk(16'd1, 0, 0, 1'b1, 1'b0, 2'b00, 16'h0000));
        ps_go(16'd0);
        chk("zero_step_done", 32'(O_done), 32'd1);
        wait_done(1, 20, "ps_zero");

        // DRP read 0x08 -> 0x1234.
        drp_rd_val = 16'h1234;
        e = mk(16'd1, 0, 1, 1'b0, 1'b0, 2'b00, 16'h1234);
        e.chk_drp = 1'b1; e.daddr = 7'h08; e.dwe = 1'b0; e.din = 16'h5555;
        exp_q.push_back(e);
        drp_go(1'b0, 7'h08, 16'h5555, 1'b0);
        wait_done(1, 50, "drp_read");

        // DRP write 0x09 <- 0xABCD; read data register unchanged.
        e = mk(16'd1, 0, 1, 1'b0, 1'b0, 2'b00, 16'h1234);
        e.chk_drp = 1'b1; e.daddr = 7'h09; e.dwe = 1'b1; e.din = 16'hABCD;
        exp_q.push_back(e);
        drp_go(1'b1, 7'h09, 16'hABCD, 1'b0);
        wait_done(1, 50, "drp_write");

        // Simultaneous DRP read and 1-step PS: DRP first, then the shift.
        drp_rd_val = 16'h5678;
        e = mk(16'd1, 0, 1, 1'b0, 1'b0, 2'b00, 16'h5678);
        e.chk_drp = 1'b1; e.daddr = 7'h0A; e.dwe = 1'b0; e.din = 16'h0000;
        exp_q.push_back(e);
        exp_q.push_back(mk(16'd2, 1, 0, 1'b1, 1'b1, 2'b00, 16'h5678));
        drp_go(1'b0, 7'h0A, 16'h0000, 1'b1);
        wait_done(2, 100, "drp_then_ps");

`ifdef TRIG_CLK_CTRL_TIMEOUT_EN
        // psdone never arrives: one psen, timeout error, phase unchanged.
        psdone_en = 1'b0;
        exp_q.push_back(mk(16'd2, 1, 0, 1'b1, 1'b1, 2'b01, 16'h5678));
        ps_go(16'd2);
        wait_done(1, 400, "ps_timeout");
        clear_err();
        psdone_en = 1'b1;
`endif

        // Lock lost: abort without psen, unlock error.
        I_locked = 1'b0;
        cycles(5);
        exp_q.push_back(mk(16'd2, 0, 0, 1'b1, 1'b1, 2'b10, 16'h5678));
        ps_go(16'd5);
        wait_done(1, 50, "ps_unlocked");
        clear_err();

        // Reset during PS_WAIT abandons the sequence.
        I_locked = 1'b1;
        cycles(5);
        base = psen_total;
        ps_go(16'd3);
        for (int i = 0; i < 20 && psen_total == base; i++) @(posedge usb_clk);
        cycles(2);
        chk("busy_before_reset", 32'(O_busy), 32'd1);
        reset_i = 1'b1;
        cycles(2);
        reset_i = 1'b0;
        chk("reset_phase", 32'(O_phase), 32'd0);
        chk("reset_busy", 32'(O_busy), 32'd0);
        chk("reset_rdata", 32'(O_drp_rdata), 32'd0);
        base = psen_total;
        cycles(12);
        chk("no_psen_after_reset", 32'(psen_total), 32'(base));
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/trig_clk_ctrl.md
TRIG_CLK_CTRL -- requirements
Module: trig_clk_ctrl

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-high; clock port usb_clk, reset port reset_i.
REQ-002 Parameters SHALL be, one per line:
  pSTEP_W, 16, width of signed step request and phase accumulator
  pTIMEOUT, 255, max usb_clk cycles waiting for psdone/drdy
REQ-003 Ports SHALL be, one per line:
  usb_clk  in  1  register/PS/DRP clock
  reset_i  in  1  sync active-high reset
  I_ps_go  in  1  pulse: start phase-shift sequence
  I_ps_steps  in  pSTEP_W  signed step count, sampled on accepted I_ps_go
  I_drp_go  in  1  pulse: start DRP access
  I_drp_write  in  1  1=write, 0=read, sampled with I_drp_go
  I_drp_addr  in  7  DRP address
  I_drp_wdata  in  16  DRP write data
  I_clear_error  in  1  clears O_error
  I_locked  in  1  MMCM locked, asynchronous
  I_psdone  in  1  MMCM phase-shift done
  I_drdy  in  1  DRP ready
  I_dout  in  16  DRP read data
  O_psen  out  1  MMCM phase-shift enable
  O_psincdec  out  1  1=increment
  O_daddr  out  7  DRP address
  O_den  out  1  DRP enable
  O_dwe  out  1  DRP write enable
  O_din  out  16  DRP write data
  O_drp_rdata  out  16  last DRP read result
  O_phase  out  pSTEP_W  signed cumulative phase steps applied
  O_busy  out  1  operation in progress
  O_done  out  1  one-cycle completion pulse
  O_error  out  2  sticky: bit0 timeout, bit1 not-locked abort

Function
REQ-004 FSM states SHALL be IDLE, PS_PULSE, PS_WAIT, DRP_ISSUE, DRP_WAIT, DONE.
REQ-005 IDLE: I_drp_go -> DRP_ISSUE; else I_ps_go with nonzero steps -> PS_PULSE; I_ps_go with zero steps -> DONE, no psen.
REQ-006 I_drp_go and I_ps_go in the same cycle: DRP served first; PS request latched as pending and started from IDLE the cycle after DONE.
REQ-007 Go pulses while O_busy=1 SHALL be ignored with no state change.
REQ-008 O_psincdec SHALL equal (steps>0), latched at acceptance, stable for the whole sequence; remaining count = |steps| in pSTEP_W unsigned bits (most-negative value valid).
REQ-009 PS_PULSE: O_psen=1 exactly one cycle -> PS_WAIT; first psen in cycle after go acceptance.
REQ-010 PS_WAIT: on I_psdone, O_phase +/-1 (wraps modulo 2^pSTEP_W), remaining -1; remaining 0 -> DONE, else PS_PULSE next cycle.
REQ-011 On each PS_PULSE entry, synchronized locked=0 SHALL abort: no psen, set O_error[1], -> DONE.
REQ-012 DRP_ISSUE: O_den=1 one cycle, O_dwe=latched write; O_daddr/O_din driven from latched values and held until DONE -> DRP_WAIT.
REQ-013 DRP_WAIT: on I_drdy, read captures I_dout into O_drp_rdata; -> DONE.
REQ-014 DONE: O_done=1 one cycle -> IDLE; O_busy=1 from cycle after acceptance through DONE inclusive.
REQ-015 I_clear_error clears O_error; coincident new error SHALL win.

Reset
REQ-016 reset_i SHALL force IDLE, clear pending PS, zero all outputs including O_phase, O_drp_rdata, O_error; mid-sequence reset abandons operation without further psen/den.

Configuration
REQ-017 Macro TRIG_CLK_CTRL_TIMEOUT_EN defined: cycle counter restarts on entry to PS_WAIT/DRP_WAIT; pTIMEOUT cycles without psdone/drdy sets O_error[0], -> DONE, remaining steps discarded. Undefined: waits indefinitely, O_error[0] constant 0.

Structure
REQ-018 State encoding, DRP address width 7 and data width 16 SHALL live in shared package trace_pkg.
REQ-019 I_locked SHALL pass through sub-module cdc_simple (two-flop synchronizer); no other sub-modules.

Verification
REQ-020 steps=+3, psdone 4 cycles after each psen -> 3 psen pulses, psincdec=1, O_phase=3, one O_done.
REQ-021 steps=-2 from phase 3 -> psincdec=0, 2 psen, O_phase=1; steps=0 -> O_done next cycle, no psen.
REQ-022 DRP read addr 0x08, drdy after 2 cycles with dout 0x1234 -> den one cycle, O_drp_rdata=0x1234; write addr 0x09 data 0xABCD -> dwe=1, din=0xABCD.
REQ-023 drp_go and ps_go (steps=1) same cycle -> DRP completes, then psen, two O_done pulses.
REQ-024 TRIG_CLK_CTRL_TIMEOUT_EN, psdone never arrives -> O_error=2'b01 after 255 cycles, O_done; I_clear_error -> 0.
REQ-025 I_locked=0, steps=5 -> no psen, O_error[1]=1; reset mid-PS_WAIT -> O_phase=0, IDLE.
